// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer: clears the shared MAC, streams len weight/input pairs
// from synchronous-read memories into it, then captures the accumulated result.
module mac_seq_ctrl #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] len,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] x_base,
  output logic              rd_en,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W-1:0] x_addr,
  input  logic [DATA_W-1:0] w_rdata,
  input  logic [DATA_W-1:0] x_rdata,
  output logic              mac_rst,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  input  logic [ACC_W-1:0]  mac_out,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  result
);

  typedef enum logic [2:0] {IDLE, CLEAR, FETCH, DRAIN, CAPTURE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic [ADDR_W-1:0]   wb_q, wb_d;
  logic [ADDR_W-1:0]   xb_q, xb_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
  logic [ACC_W-1:0]    result_q, result_d;
  logic                fetch_c;
  logic                clear_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      len_q    <= '0;
      wb_q     <= '0;
      xb_q     <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      wb_q     <= wb_d;
      xb_q     <= xb_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    wb_d     = wb_q;
    xb_d     = xb_q;
    idx_d    = idx_q;
    result_d = result_q;
    done_d   = 1'b0;
    fetch_c  = 1'b0;
    clear_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = len;
          wb_d    = w_base;
          xb_d    = x_base;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        clear_c = 1'b1;
        idx_d   = '0;
        state_d = (len_q == '0) ? CAPTURE : FETCH;
      end
      FETCH: begin
        fetch_c = 1'b1;
        idx_d   = idx_q + ADDR_W'(1);
        if (idx_q == len_q - ADDR_W'(1)) state_d = DRAIN;
      end
      DRAIN: state_d = CAPTURE;
      CAPTURE: begin
        result_d = mac_out;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read data arrives one cycle after the strobe, so the operand-valid flag
  // is simply the strobe delayed by one clock.
  assign valid_d = fetch_c & ~rst;
  assign rd_en   = fetch_c & ~rst;
  assign w_addr  = wb_q + idx_q;
  assign x_addr  = xb_q + idx_q;
  assign mac_rst = rst | clear_c;
  assign mac_a   = (valid_q && !rst) ? w_rdata : '0;
  assign mac_b   = (valid_q && !rst) ? x_rdata : '0;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign result  = result_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: memory and MAC models around the DUT, table-driven
// dot products checked through a result scoreboard, plus abort/overlap cases.
module tb_mac_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [7:0]  len, w_base, x_base, w_addr, x_addr, w_rdata, x_rdata, mac_a, mac_b;
  logic        rd_en, mac_rst, busy, done;
  logic [15:0] mac_out, result;

  logic [7:0]  w_mem [256];
  logic [7:0]  x_mem [256];
  int          total = 0;
  int          bad = 0;
  logic [15:0] sb_q [$];

  typedef struct {
    logic [7:0]  len;
    logic [7:0]  wb;
    logic [7:0]  xb;
    logic [15:0] exp;
    bit          fixed;
  } vec_t;
  vec_t vecs [5];

  mac_seq_ctrl #(.ADDR_W(8), .DATA_W(8), .ACC_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .w_base(w_base), .x_base(x_base),
    .rd_en(rd_en), .w_addr(w_addr), .x_addr(x_addr), .w_rdata(w_rdata), .x_rdata(x_rdata),
    .mac_rst(mac_rst), .mac_a(mac_a), .mac_b(mac_b), .mac_out(mac_out),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) begin
      w_rdata <= w_mem[w_addr];
      x_rdata <= x_mem[x_addr];
    end
  end

  always @(posedge clk) begin
    if (mac_rst) mac_out <= '0;
    else         mac_out <= mac_out + ({8'd0, mac_a} * {8'd0, mac_b});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] dot(input logic [7:0] l, input logic [7:0] wb, input logic [7:0] xb);
    logic [15:0] acc;
    logic [7:0]  wa, xa;
    acc = '0;
    for (int unsigned i = 0; i < l; i++) begin
      wa  = wb + 8'(i);
      xa  = xb + 8'(i);
      acc = acc + ({8'd0, w_mem[wa]} * {8'd0, x_mem[xa]});
    end
    return acc;
  endfunction

  task automatic drive_start(input logic [7:0] l, input logic [7:0] wb, input logic [7:0] xb);
    start  = 1'b1;
    len    = l;
    w_base = wb;
    x_base = xb;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  // Follows one operation from the cycle after its accepting edge to its done cycle.
  task automatic track(input logic [7:0] l, input logic [7:0] wb, input logic [7:0] xb, input bit poke);
    int          n = 0;
    int          rd = 0;
    int          mr = 0;
    bit          seen = 0;
    logic [7:0]  ea;
    logic [15:0] e;
    if (mac_rst) mr++;
    while (n < 300 && !seen) begin
      @(posedge clk); #1;
      n++;
      if (poke && n == 3) begin
        start  = 1'b1;
        len    = 8'd2;
        w_base = 8'd7;
      end
      if (poke && n == 4) start = 1'b0;
      if (done) seen = 1;
      else begin
        if (rd_en) begin
          ea = wb + 8'(rd);
          chk("w_addr", {24'd0, w_addr}, {24'd0, ea});
          ea = xb + 8'(rd);
          chk("x_addr", {24'd0, x_addr}, {24'd0, ea});
          rd++;
        end
        if (mac_rst) mr++;
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done expected done within 300 cycles");
      return;
    end
    chk("done_latency", n, (l == 8'd0) ? 2 : int'(l) + 3);
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_underflow: got done expected no pending result");
    end else begin
      e = sb_q.pop_front();
      chk("result", {16'd0, result}, {16'd0, e});
    end
    chk("busy_at_done", {31'd0, busy}, 0);
    chk("rd_en_cycles", rd, {24'd0, l});
    chk("mac_rst_cycles", mr, 1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      w_mem[i] = 8'($urandom);
      x_mem[i] = 8'($urandom);
    end
    w_mem[0] = 8'd5;   w_mem[1] = 8'd10;  w_mem[2] = 8'd255;
    x_mem[0] = 8'd3;   x_mem[1] = 8'd2;   x_mem[2] = 8'd1;
    w_mem[8'h20] = 8'd255; w_mem[8'h21] = 8'd255;
    x_mem[8'h30] = 8'd255; x_mem[8'h31] = 8'd255;

    vecs[0] = '{len: 8'd3, wb: 8'd0,    xb: 8'd0,    exp: 16'd290,   fixed: 1'b1};
    vecs[1] = '{len: 8'd2, wb: 8'h20,   xb: 8'h30,   exp: 16'd64514, fixed: 1'b1};
    vecs[2] = '{len: 8'd0, wb: 8'd0,    xb: 8'd0,    exp: 16'd0,     fixed: 1'b1};
    vecs[3] = '{len: 8'd4, wb: 8'd254,  xb: 8'd10,   exp: 16'd0,     fixed: 1'b0};
    vecs[4] = '{len: 8'd7, wb: 8'd100,  xb: 8'd200,  exp: 16'd0,     fixed: 1'b0};

    rst = 1'b1; start = 1'b0; len = '0; w_base = '0; x_base = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",    {31'd0, busy},    0);
    chk("rst_done",    {31'd0, done},    0);
    chk("rst_result",  {16'd0, result},  0);
    chk("rst_rd_en",   {31'd0, rd_en},   0);
    chk("rst_mac_rst", {31'd0, mac_rst}, 1);
    chk("rst_mac_a",   {24'd0, mac_a},   0);
    chk("rst_mac_b",   {24'd0, mac_b},   0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      drive_start(vecs[i].len, vecs[i].wb, vecs[i].xb);
      sb_q.push_back(vecs[i].fixed ? vecs[i].exp : dot(vecs[i].len, vecs[i].wb, vecs[i].xb));
      track(vecs[i].len, vecs[i].wb, vecs[i].xb, 1'b0);
      @(posedge clk); #1;
      chk("done_single", {31'd0, done}, 0);
    end

    // start mid-FETCH is ignored; start in the done cycle launches the next run
    drive_start(8'd5, 8'd40, 8'd60);
    sb_q.push_back(dot(8'd5, 8'd40, 8'd60));
    track(8'd5, 8'd40, 8'd60, 1'b1);
    drive_start(8'd3, 8'd0, 8'd0);
    chk("chain_done_low", {31'd0, done},    0);
    chk("chain_clear",    {31'd0, mac_rst}, 1);
    chk("chain_busy",     {31'd0, busy},    1);
    sb_q.push_back(16'd290);
    track(8'd3, 8'd0, 8'd0, 1'b0);
    @(posedge clk); #1;

    // reset in the middle of FETCH
    drive_start(8'd8, 8'd0, 8'd0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("abort_in_fetch", {31'd0, rd_en}, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy",    {31'd0, busy},    0);
    chk("abort_rd_en",   {31'd0, rd_en},   0);
    chk("abort_result",  {16'd0, result},  0);
    chk("abort_done",    {31'd0, done},    0);
    chk("abort_mac_rst", {31'd0, mac_rst}, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_done2",   {31'd0, done},    0);
    chk("abort_busy2",   {31'd0, busy},    0);
    drive_start(8'd3, 8'd0, 8'd0);
    sb_q.push_back(16'd290);
    track(8'd3, 8'd0, 8'd0, 1'b0);
    @(posedge clk); #1;
    chk("sb_empty", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
Sequencer that computes one dot product of length len on the shared 8x8->16 MAC datapath.
- Clears the MAC, streams weight/input pairs from two synchronous-read memories into it, then captures the accumulated result with a done pulse.
- Sits between the spike/neuron scheduler (start/len/base) and the MAC plus weight/input SRAMs.
- The MAC accumulates mac_a*mac_b on every clock and clears on mac_rst. The controller drives zero operands whenever no valid pair is present.

Parameters:
ADDR_W, 8, memory address width; also the width of len.
DATA_W, 8, operand width (matches MAC a/b).
ACC_W, 16, accumulator/result width (matches MAC out).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request a dot product; sampled only in IDLE
len  in  ADDR_W  number of pairs, 0..2^ADDR_W-1; latched on accepted start
w_base  in  ADDR_W  weight start address; latched on start
x_base  in  ADDR_W  input start address; latched on start
rd_en  out  1  memory read strobe
w_addr  out  ADDR_W  weight memory address
x_addr  out  ADDR_W  input memory address
w_rdata  in  DATA_W  weight data, valid 1 cycle after rd_en
x_rdata  in  DATA_W  input data, valid 1 cycle after rd_en
mac_rst  out  1  MAC accumulator clear
mac_a  out  DATA_W  MAC operand a
mac_b  out  DATA_W  MAC operand b
mac_out  in  ACC_W  MAC accumulator value
busy  out  1  operation in progress
done  out  1  one-cycle pulse: result valid
result  out  ACC_W  captured dot product; holds until next capture

Behaviour:
- Reset (sync, rst=1): state=IDLE, idx=0, valid_d=0, busy=0, done=0, result=0, rd_en=0. mac_rst=1 while rst is high; mac_a=mac_b=0.
- States: IDLE, CLEAR, FETCH, DRAIN, CAPTURE. E0 is the edge that samples start.
- IDLE: start=1 latches len/bases and goes to CLEAR (after E0). Otherwise stay in IDLE.
- CLEAR: mac_rst=1 and operands are 0; the MAC clears at E1.
  - len!=0: go to FETCH with idx=0.
  - len==0: go to CAPTURE.
- FETCH: rd_en=1, w_addr=w_base+idx, x_addr=x_base+idx, both mod 2^ADDR_W (wrap-around, no error). idx increments each cycle. After issuing idx=len-1, go to DRAIN.
- valid_d is rd_en registered. mac_a=w_rdata and mac_b=x_rdata when valid_d=1; otherwise both are 0.
- DRAIN: rd_en=0 for one cycle; the last pair is applied. Then go to CAPTURE.
- CAPTURE: mac_out is final. At the next edge result<=mac_out, done<=1 for exactly one cycle, and state returns to IDLE.
- Latency:
  - len>=1: done high in the cycle after E(len+3).
  - len=0: done high after E2 with result=0.
  - Throughput is 1 pair/cycle.
- busy: 1 in CLEAR, FETCH, DRAIN and CAPTURE; 0 in IDLE, including the done cycle.
- start while busy is ignored, with no queueing; len/base changes mid-operation have no effect. start during the done cycle (state IDLE) is accepted.
- Arithmetic: the controller adds nothing. Accumulation wraps modulo 2^ACC_W inside the MAC and result reports the wrapped value; there is no saturation or overflow flag.
- Reset mid-operation aborts immediately. result is cleared to 0, no done is issued, and mac_rst=1.
- mac_rst is high only in CLEAR or under rst; never during FETCH, DRAIN or CAPTURE.

Test Plan:
- len=3, w_base=0, x_base=0, W={5,10,255}, X={3,2,1}:
  - result=290 (0x0122).
  - done pulses once, in the cycle after E6.
  - rd_en high exactly 3 cycles; busy low at done.
- len=2, W={255,255}, X={255,255} -> result=64514 (130050 mod 65536), confirming wrap-around.
- len=0 -> mac_rst pulses once, rd_en never asserts, result=0, done in the cycle after E2.
- w_base=254, x_base=10, len=4 -> w_addr sequence 254,255,0,1 and x_addr 10..13; result matches the software dot product.
- start pulsed mid-FETCH with a different len -> ignored. Result is for the original len, with a single done; a start held high in the done cycle launches a second operation whose CLEAR follows immediately.
- rst asserted during FETCH of a len=8 run:
  - Next cycle: IDLE, busy=0, rd_en=0, result=0, no done.
  - A fresh len=3 run then produces 290 exactly as in the first scenario.
